// File: rtl/pdp8_pkg.sv
// Shared PDP-8/E constants: IOT opcode, device codes and CPU major-state codes.
package pdp8_pkg;

    localparam logic [2:0] IOT_OP     = 3'o6;

    localparam logic [5:0] DEV_INT    = 6'o00;
    localparam logic [5:0] DEV_KBD    = 6'o03;
    localparam logic [5:0] DEV_TTO    = 6'o04;
    localparam logic [5:0] DEV_MEM_LO = 6'o20;
    localparam logic [5:0] DEV_MEM_HI = 6'o27;

    localparam logic [4:0] ST_FETCH   = 5'd0;
    localparam logic [4:0] ST_DEFER   = 5'd1;
    localparam logic [4:0] ST_EXECUTE = 5'd2;
    localparam logic [4:0] ST_BREAK   = 5'd3;
    localparam logic [4:0] ST_IOT     = 5'd4;
    localparam logic [4:0] ST_HALT    = 5'd5;
    localparam logic [4:0] ST_DISP    = 5'd6;

    // Memory-extension devices occupy one contiguous octal block.
    function automatic logic is_mem_dev(input logic [5:0] dev);
        return (dev >= DEV_MEM_LO) && (dev <= DEV_MEM_HI);
    endfunction

endpackage

// File: rtl/pdp8_imux_if.sv
// IOT input-mux bus bundle; all data buses are PDP-8 ordered [0:11] (bit 0 = MSB).
interface pdp8_imux_if;
    logic [4:0]  state;
    logic [0:11] instruction;
    logic [0:11] mem_reg_bus;
    logic [0:11] serial_data_bus;
    logic        iskip;
    logic        sskip;
    logic        mskip;
    logic        skip;
    logic [0:11] in_bus;
    logic [0:11] bus_display;

    modport master (
        output state, instruction, mem_reg_bus, serial_data_bus, iskip, sskip, mskip,
        input  skip, in_bus, bus_display
    );

    modport slave (
        input  state, instruction, mem_reg_bus, serial_data_bus, iskip, sskip, mskip,
        output skip, in_bus, bus_display
    );
endinterface

// File: rtl/pdp8_imux_iot_dev_decode.sv
// IOT device-field decoder: instruction -> one-hot {sel_int, sel_ser, sel_mem}.
// Memory-extension decode is present only when IMUX_MEMEXT_EN is defined.
module iot_dev_decode
    import pdp8_pkg::*;
(
    input  logic [0:11] instruction_i,
    output logic        sel_int_o,
    output logic        sel_ser_o,
    output logic        sel_mem_o
);

    logic [5:0] dev_s;

    assign dev_s = instruction_i[3:8];

    // Device select; function bits 9..11 take no part in selection.
    always_comb begin
        sel_int_o = 1'b0;
        sel_ser_o = 1'b0;
        sel_mem_o = 1'b0;
        if (instruction_i[0:2] == IOT_OP) begin
            case (dev_s)
                DEV_INT:          sel_int_o = 1'b1;
                DEV_KBD, DEV_TTO: sel_ser_o = 1'b1;
                default: begin
`ifdef IMUX_MEMEXT_EN
                    sel_mem_o = is_mem_dev(dev_s);
`else
                    sel_mem_o = 1'b0;
`endif
                end
            endcase
        end else begin
            sel_mem_o = 1'b0;
        end
    end

endmodule

// File: rtl/pdp8_imux.sv
// PDP-8/E IOT input multiplexer with registered front-panel copy of the input bus.
// Optional memory-extension decode: define IMUX_MEMEXT_EN.
module pdp8_imux
    import pdp8_pkg::*;
#(
    parameter logic [4:0] DISP_STATE = ST_DISP
) (
    input  logic           clk,
    input  logic           reset,
    pdp8_imux_if.slave     bus
);

    logic        sel_int_s;
    logic        sel_ser_s;
    logic        sel_mem_s;
    logic        skip_s;
    logic [0:11] in_bus_s;
    logic [0:11] bus_display_d;
    logic [0:11] bus_display_q;

    iot_dev_decode u_dec (
        .instruction_i (bus.instruction),
        .sel_int_o     (sel_int_s),
        .sel_ser_o     (sel_ser_s),
        .sel_mem_o     (sel_mem_s)
    );

    // Selects are one-hot, so non-selected devices' flags and data never leak through.
    always_comb begin
        skip_s   = 1'b0;
        in_bus_s = 12'o0000;
        if (sel_int_s) begin
            skip_s = bus.iskip;
        end else if (sel_ser_s) begin
            skip_s   = bus.sskip;
            in_bus_s = bus.serial_data_bus;
        end else if (sel_mem_s) begin
            skip_s   = bus.mskip;
            in_bus_s = bus.mem_reg_bus;
        end else begin
            skip_s   = 1'b0;
            in_bus_s = 12'o0000;
        end
    end

    // Display capture during the display state, otherwise hold.
    always_comb begin
        if (bus.state == DISP_STATE) begin
            bus_display_d = in_bus_s;
        end else begin
            bus_display_d = bus_display_q;
        end
    end

    // Display register; reset wins over capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_display_q <= 12'o0000;
        end else begin
            bus_display_q <= bus_display_d;
        end
    end

    assign bus.skip        = skip_s;
    assign bus.in_bus      = in_bus_s;
    assign bus.bus_display = bus_display_q;

endmodule

// File: tb/tb_pdp8_imux.sv
// Self-checking bench for pdp8_imux: scoreboarded combinational mux plus display-register sequence.
module tb_pdp8_imux;
    import pdp8_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    typedef struct {
        string      tag;
        logic       skip;
        logic [11:0] bus;
    } exp_t;

    exp_t exp_q[$];

    pdp8_imux_if bus_if ();

    pdp8_imux dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %o, expected %o", tag, obs, exp);
        end
    endtask

    // Reference model written from the decode table in integer arithmetic.
    function automatic exp_t model(input string tag, input int instr, input int mem, input int ser,
                                   input bit is_, input bit ss, input bit ms);
        exp_t e;
        int   dev;
        e.tag  = tag;
        e.skip = 1'b0;
        e.bus  = 12'o0000;
        dev    = (instr / 8) % 64;
        if (instr / 512 == 6) begin
            if (dev == 0) begin
                e.skip = is_;
            end else if (dev == 3 || dev == 4) begin
                e.skip = ss;
                e.bus  = ser[11:0];
            end else if (dev >= 16 && dev <= 23) begin
`ifdef IMUX_MEMEXT_EN
                e.skip = ms;
                e.bus  = mem[11:0];
`endif
            end
        end
        return e;
    endfunction

    task automatic apply(input string tag, input int instr, input int mem, input int ser,
                         input bit is_, input bit ss, input bit ms);
        exp_t e;
        @(negedge clk);
        bus_if.instruction     = instr[11:0];
        bus_if.mem_reg_bus     = mem[11:0];
        bus_if.serial_data_bus = ser[11:0];
        bus_if.iskip           = is_;
        bus_if.sskip           = ss;
        bus_if.mskip           = ms;
        exp_q.push_back(model(tag, instr, mem, ser, is_, ss, ms));
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".skip"}, {11'd0, bus_if.skip}, {11'd0, e.skip});
        check({e.tag, ".in_bus"}, bus_if.in_bus, e.bus);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus_if.state           = ST_DISP;
        bus_if.instruction     = 12'o6030;
        bus_if.mem_reg_bus     = 12'o0000;
        bus_if.serial_data_bus = 12'o5555;
        bus_if.iskip           = 1'b0;
        bus_if.sskip           = 1'b0;
        bus_if.mskip           = 1'b0;

        // Reset held 5 cycles even while in display state with live data.
        repeat (5) @(posedge clk);
        #1;
        check("disp_reset", bus_if.bus_display, 12'o0000);

        // Combinational outputs unaffected by reset.
        apply("in_reset_ser", 'o6030, 'o0000, 'o5555, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        bus_if.state = ST_FETCH;
        reset = 1'b0;

        apply("int_6000", 'o6000, 'o0000, 'o0000, 1'b1, 1'b0, 1'b0);
        apply("int_6007", 'o6007, 'o0000, 'o0000, 1'b0, 1'b0, 1'b0);
        apply("int_ignore", 'o6007, 'o0000, 'o0000, 1'b0, 1'b1, 1'b1);
        apply("ser_6030", 'o6030, 'o0000, 'o7070, 1'b0, 1'b1, 1'b0);
        apply("ser_6037", 'o6037, 'o0000, 'o7070, 1'b0, 1'b1, 1'b0);
        apply("ser_6047", 'o6047, 'o0000, 'o7070, 1'b0, 1'b1, 1'b0);
        apply("ser_noskip", 'o6047, 'o0000, 'o7070, 1'b0, 1'b0, 1'b0);
        apply("mem_6224", 'o6224, 'o6363, 'o0000, 1'b0, 1'b0, 1'b1);
        apply("mem_6200", 'o6200, 'o1234, 'o4321, 1'b1, 1'b1, 1'b1);
        apply("mem_6277", 'o6277, 'o1234, 'o4321, 1'b1, 1'b1, 1'b1);
        apply("other_6300", 'o6300, 'o1234, 'o4321, 1'b1, 1'b1, 1'b1);
        apply("other_6170", 'o6170, 'o1234, 'o4321, 1'b1, 1'b1, 1'b1);
        apply("other_6010", 'o6010, 'o1234, 'o4321, 1'b1, 1'b1, 1'b1);
        apply("non_iot", 'o7070, 'o6363, 'o7070, 1'b1, 1'b1, 1'b1);
        apply("non_iot_5030", 'o5030, 'o6363, 'o7070, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            int instr;
            instr = ($urandom_range(0, 3) != 0) ? ('o6000 | $urandom_range(0, 'o777))
                                               : $urandom_range(0, 'o7777);
            apply("rand", instr, $urandom_range(0, 'o7777), $urandom_range(0, 'o7777),
                  1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Display capture: one clock after entering the display state.
        apply("disp_src", 'o6030, 'o0000, 'o7070, 1'b0, 1'b1, 1'b0);
        bus_if.state = ST_DISP;
        @(posedge clk);
        #1;
        check("disp_capture", bus_if.bus_display, 12'o7070);

        // Leave display state and change the bus: value must hold.
        @(negedge clk);
        bus_if.state = ST_EXECUTE;
        bus_if.serial_data_bus = 12'o1111;
        repeat (3) @(posedge clk);
        #1;
        check("disp_hold", bus_if.bus_display, 12'o7070);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("disp_rereset", bus_if.bus_display, 12'o0000);

        if (exp_q.size() != 0) begin
            check("sb_leftover", 12'(exp_q.size()), 12'o0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
